// File: rtl/p251_pkg.sv
// rtl/p251_pkg.sv - shared constants and FSM encoding for the mod-251 rejection sampler
package p251_pkg;

   // Field modulus; bytes at or above this value are rejected.
   localparam logic [7:0] Q = 8'd251;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SCAN = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/p251_lt_q.sv
// rtl/p251_lt_q.sv - combinational test of one byte against the modulus
module p251_lt_q
   import p251_pkg::*;
(
   input  logic [7:0] i_byte,
   output logic       o_lt_q
);

   // A byte is a usable field element only when strictly below Q.
   always_comb begin
      o_lt_q = (i_byte < Q);
   end

endmodule

// File: rtl/p251_rejection_sampler.sv
// rtl/p251_rejection_sampler.sv - turns random words into uniform elements of GF(251)
module p251_rejection_sampler
   import p251_pkg::*;
#(
   parameter int WORD_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16
)
(
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   input  logic [COUNT_WIDTH-1:0] i_num_elems,
   input  logic [WORD_WIDTH-1:0]  i_word,
   input  logic                   i_word_valid,
   output logic                   o_word_ready,
   output logic [7:0]             o_elem,
   output logic                   o_elem_valid,
   input  logic                   i_elem_ready,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [COUNT_WIDTH-1:0] o_rej_count
);

   localparam int NUM_BYTES = WORD_WIDTH / 8;
   localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   state_e                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] target_q, target_d;
   logic [COUNT_WIDTH-1:0] elem_cnt_q, elem_cnt_d;
   logic [COUNT_WIDTH-1:0] rej_cnt_q, rej_cnt_d;
   logic [WORD_WIDTH-1:0]  word_q, word_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [7:0]             elem_q, elem_d;
   logic                   elem_valid_q, elem_valid_d;

   logic [NUM_BYTES-1:0][7:0] word_bytes;
   logic [IDX_W-1:0]          next_idx;
   logic                      last_byte;
   logic [COUNT_WIDTH-1:0]    cnt_inc;
   logic                      hit_target;
   logic [7:0]                probe_byte;
   logic                      probe_lt;

   // The byte presented in the next cycle: byte 0 of the incoming word when
   // loading, otherwise the following byte of the buffered word. Its test
   // result is registered so o_elem_valid comes straight from a flop.
   always_comb begin
      word_bytes = word_q;
      next_idx   = idx_q + IDX_W'(1);
      last_byte  = (idx_q == IDX_W'(NUM_BYTES - 1));
      cnt_inc    = elem_cnt_q + COUNT_WIDTH'(1);
      hit_target = (cnt_inc == target_q);
      probe_byte = (state_q == ST_LOAD) ? i_word[7:0] : word_bytes[next_idx];
   end

   p251_lt_q u_lt_q (
      .i_byte (probe_byte),
      .o_lt_q (probe_lt)
   );

   // Next-state and datapath updates for the IDLE/LOAD/SCAN/DONE sequence.
   always_comb begin
      state_d      = state_q;
      target_d     = target_q;
      elem_cnt_d   = elem_cnt_q;
      rej_cnt_d    = rej_cnt_q;
      word_d       = word_q;
      idx_d        = idx_q;
      elem_d       = elem_q;
      elem_valid_d = elem_valid_q;

      unique case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               target_d   = i_num_elems;
               elem_cnt_d = '0;
               rej_cnt_d  = '0;
               state_d    = (i_num_elems == '0) ? ST_DONE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (i_word_valid) begin
               word_d       = i_word;
               idx_d        = '0;
               elem_d       = i_word[7:0];
               elem_valid_d = probe_lt;
               state_d      = ST_SCAN;
            end
         end
         ST_SCAN: begin
            if (elem_valid_q) begin
               // Element waits for the consumer; nothing moves until accepted.
               if (i_elem_ready) begin
                  elem_cnt_d = cnt_inc;
                  if (hit_target) begin
                     elem_valid_d = 1'b0;
                     state_d      = ST_DONE;
                  end else if (last_byte) begin
                     elem_valid_d = 1'b0;
                     state_d      = ST_LOAD;
                  end else begin
                     idx_d        = next_idx;
                     elem_d       = probe_byte;
                     elem_valid_d = probe_lt;
                  end
               end
            end else begin
               // Rejected byte: dropped in one cycle, counter saturates.
               if (rej_cnt_q != '1) begin
                  rej_cnt_d = rej_cnt_q + COUNT_WIDTH'(1);
               end
               if (last_byte) begin
                  state_d = ST_LOAD;
               end else begin
                  idx_d        = next_idx;
                  elem_d       = probe_byte;
                  elem_valid_d = probe_lt;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; reset abandons any run in progress.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         target_q     <= '0;
         elem_cnt_q   <= '0;
         rej_cnt_q    <= '0;
         word_q       <= '0;
         idx_q        <= '0;
         elem_q       <= '0;
         elem_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         target_q     <= target_d;
         elem_cnt_q   <= elem_cnt_d;
         rej_cnt_q    <= rej_cnt_d;
         word_q       <= word_d;
         idx_q        <= idx_d;
         elem_q       <= elem_d;
         elem_valid_q <= elem_valid_d;
      end
   end

   // Status outputs decoded directly from registered state.
   always_comb begin
      o_word_ready = (state_q == ST_LOAD);
      o_busy       = (state_q != ST_IDLE);
      o_done       = (state_q == ST_DONE);
      o_elem       = elem_q;
      o_elem_valid = elem_valid_q;
      o_rej_count  = rej_cnt_q;
   end

endmodule

// File: tb/tb_p251_rejection_sampler.sv
// tb/tb_p251_rejection_sampler.sv - scoreboard bench for the GF(251) rejection sampler
module tb_p251_rejection_sampler;

   localparam int WW = 32;
   localparam int CW = 16;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_start;
   logic [CW-1:0] i_num_elems;
   logic [WW-1:0] i_word;
   logic          i_word_valid;
   logic          o_word_ready;
   logic [7:0]    o_elem;
   logic          o_elem_valid;
   logic          i_elem_ready;
   logic          o_busy;
   logic          o_done;
   logic [CW-1:0] o_rej_count;

   p251_rejection_sampler #(.WORD_WIDTH(WW), .COUNT_WIDTH(CW)) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_start      (i_start),
      .i_num_elems  (i_num_elems),
      .i_word       (i_word),
      .i_word_valid (i_word_valid),
      .o_word_ready (o_word_ready),
      .o_elem       (o_elem),
      .o_elem_valid (o_elem_valid),
      .i_elem_ready (i_elem_ready),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_rej_count  (o_rej_count)
   );

   always #5 i_clk = ~i_clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] stim_words[$];
   logic [31:0] feed_q[$];
   logic [7:0]  exp_q[$];
   int          exp_rej;
   int          exp_words;
   int          words_taken;
   int          done_count;
   int          ready_mode = 0;
   bit          zero_run = 0;
   bit          stalled = 0;
   logic [7:0]  stall_elem;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: walk the words byte by byte in little-endian order, keep
   // values below 251 until the target is met, count the rest as rejects.
   task automatic model(input int num);
      int         cnt;
      bit         stop;
      logic [7:0] b;
      cnt       = 0;
      stop      = 0;
      exp_rej   = 0;
      exp_words = 0;
      if (num > 0) begin
         foreach (stim_words[i]) begin
            if (!stop) begin
               exp_words++;
               for (int k = 0; k < 4; k++) begin
                  if (!stop) begin
                     b = stim_words[i][8*k +: 8];
                     if (int'(b) < 251) begin
                        exp_q.push_back(b);
                        cnt++;
                        if (cnt == num) stop = 1;
                     end else if (exp_rej < 65535) begin
                        exp_rej++;
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic start_run(input int num);
      exp_q.delete();
      model(num);
      feed_q      = stim_words;
      words_taken = 0;
      done_count  = 0;
      zero_run    = (num == 0);
      @(posedge i_clk); #1;
      i_start     = 1'b1;
      i_num_elems = CW'(num);
      @(posedge i_clk); #1;
      i_start     = 1'b0;
   endtask

   task automatic finish_run(input string name);
      for (int i = 0; i < 2000 && done_count == 0; i++) @(negedge i_clk);
      chk({name, "_done_seen"}, 32'(done_count > 0), 32'd1);
      @(negedge i_clk);
      @(negedge i_clk);
      chk({name, "_done_pulses"}, 32'(done_count), 32'd1);
      chk({name, "_rej_count"}, 32'(o_rej_count), 32'(exp_rej));
      chk({name, "_words"}, 32'(words_taken), 32'(exp_words));
      chk({name, "_elems_left"}, 32'(exp_q.size()), 32'd0);
      chk({name, "_idle"}, {30'd0, o_busy, o_done}, 32'd0);
      feed_q.delete();
      zero_run = 0;
   endtask

   task automatic run(input string name, input int num);
      start_run(num);
      finish_run(name);
   endtask

   task automatic chk_zero_outputs(input string name);
      chk({name, "_word_ready"}, 32'(o_word_ready), 32'd0);
      chk({name, "_elem"}, 32'(o_elem), 32'd0);
      chk({name, "_elem_valid"}, 32'(o_elem_valid), 32'd0);
      chk({name, "_busy"}, 32'(o_busy), 32'd0);
      chk({name, "_done"}, 32'(o_done), 32'd0);
      chk({name, "_rej"}, 32'(o_rej_count), 32'd0);
   endtask

   // Word source: offers queued words with random gaps, retires on handshake.
   initial begin
      bit take;
      forever begin
         @(negedge i_clk);
         take = i_word_valid && o_word_ready;
         @(posedge i_clk); #1;
         if (take && feed_q.size() > 0) begin
            void'(feed_q.pop_front());
            words_taken++;
         end
         if (feed_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            i_word_valid = 1'b1;
            i_word       = feed_q[0];
         end else begin
            i_word_valid = 1'b0;
            i_word       = $urandom;
         end
      end
   end

   // Consumer ready: random, forced high or forced low.
   initial begin
      forever begin
         @(posedge i_clk); #1;
         case (ready_mode)
            0:       i_elem_ready = ($urandom_range(0, 2) != 0);
            1:       i_elem_ready = 1'b1;
            default: i_elem_ready = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on each accepted element, checks hold
   // behaviour under backpressure and watches control outputs.
   initial begin
      logic [7:0] exp_b;
      forever begin
         @(negedge i_clk);
         if (o_done) done_count++;
         if (zero_run) chk("zero_word_ready", 32'(o_word_ready), 32'd0);
         if (stalled) begin
            chk("stall_valid", 32'(o_elem_valid), 32'd1);
            chk("stall_elem", 32'(o_elem), 32'(stall_elem));
            stalled = 0;
         end
         if (o_elem_valid) begin
            chk("valid_in_scan", {30'd0, o_busy, o_word_ready}, 32'd2);
            if (i_elem_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_elem", 32'(o_elem), 32'hffff_ffff);
               end else begin
                  exp_b = exp_q.pop_front();
                  chk("elem", 32'(o_elem), 32'(exp_b));
               end
            end else begin
               stalled    = 1;
               stall_elem = o_elem;
            end
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int         num;
      int         have;
      logic [7:0] b;
      logic [31:0] w;

      i_rst        = 1'b1;
      i_start      = 1'b0;
      i_num_elems  = '0;
      i_word       = '0;
      i_word_valid = 1'b0;
      i_elem_ready = 1'b0;
      repeat (3) @(negedge i_clk);
      chk_zero_outputs("reset");
      @(posedge i_clk); #1;
      i_rst = 1'b0;

      stim_words = {32'hFC0AFB05};
      run("basic", 2);

      stim_words = {32'h01020304};
      run("zero", 0);

      stim_words = {32'hFFFFFFFF, 32'h00010203};
      run("multi", 3);

      stim_words = {32'hFFFBFAFA};
      run("bound_a", 2);

      stim_words = {32'hFB00FBFB};
      run("bound_b", 1);

      // Backpressure on the first element.
      ready_mode = 2;
      stim_words = {32'hFC0AFB05};
      start_run(2);
      for (int i = 0; i < 100 && !o_elem_valid; i++) @(negedge i_clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge i_clk);
         chk("bp_valid", 32'(o_elem_valid), 32'd1);
         chk("bp_elem", 32'(o_elem), 32'h05);
         chk("bp_rej", 32'(o_rej_count), 32'd0);
      end
      ready_mode = 1;
      finish_run("bp");

      // Reset after the first of four elements.
      ready_mode = 1;
      stim_words = {32'h04030201};
      start_run(4);
      for (int i = 0; i < 100 && exp_q.size() != 3; i++) @(negedge i_clk);
      chk("rst_progress", 32'(exp_q.size()), 32'd3);
      @(posedge i_clk); #1;
      i_rst = 1'b1;
      #1;
      chk_zero_outputs("rst_mid");
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      exp_q.delete();
      feed_q.delete();
      @(negedge i_clk);
      chk_zero_outputs("rst_idle");
      stim_words = {32'hFFFFFF07};
      run("after_rst", 1);

      // Random runs, some with a start pulse issued while busy.
      ready_mode = 0;
      for (int r = 0; r < 20; r++) begin
         num  = $urandom_range(1, 12);
         have = 0;
         stim_words.delete();
         while (have < num) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
               b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(248, 255))
                                               : 8'($urandom_range(0, 255));
               w[8*k +: 8] = b;
               if (int'(b) < 251) have++;
            end
            stim_words.push_back(w);
         end
         start_run(num);
         if (r % 3 == 0) begin
            @(posedge i_clk); #1;
            if (o_busy) begin
               i_start     = 1'b1;
               i_num_elems = CW'($urandom_range(0, 5));
               @(posedge i_clk); #1;
               i_start     = 1'b0;
            end
         end
         finish_run("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
